nonce_sequencer: RTL

// - Upstream nonce source for the mining controller. Sweeps a 32-bit nonce over [start_nonce, end_nonce].
// - Offers each candidate with its header word address (valid/ready); the controller writes it into header BRAM.
// - Then waits for the controller's verdict on that candidate: found or next.
// - Records the winning nonce. Reports exhaustion of the range without wrapping.

---
 rtl/nonce_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/nonce_sequencer.sv
// Nonce sequencer: sweeps a nonce range and offers each candidate to the mining controller.
// Build option: define NONCE_BYTESWAP_EN to present nonce_out byte-reversed.
module nonce_sequencer #(
    parameter int              NONCE_W    = 32,
    parameter int              ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] NONCE_ADDR = 16'd19,
    parameter int              STEP       = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [NONCE_W-1:0] start_nonce,
    input  logic [NONCE_W-1:0] end_nonce,
    input  logic               nonce_ready,
    input  logic               found,
    input  logic               next,
    output logic [NONCE_W-1:0] nonce_out,
    output logic [ADDR_W-1:0]  nonce_addr,
    output logic               nonce_valid,
    output logic               busy,
    output logic               done,
    output logic               exhausted,
    output logic [NONCE_W-1:0] found_nonce,
    output logic [NONCE_W-1:0] attempts
);
    // state     | meaning
    // IDLE      | no sweep in progress
    // PRESENT   | candidate offered, waiting for nonce_ready
    // WAIT      | candidate taken, waiting for found/next verdict
    // FOUND     | winning nonce recorded
    // EXHAUSTED | range ended without a hit
    typedef enum logic [2:0] {
        IDLE,
        PRESENT,
        WAIT,
        FOUND,
        EXHAUSTED
    } state_t;

    localparam logic [NONCE_W:0] STEP_EXT = (NONCE_W+1)'(STEP);

    state_t             state, state_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [NONCE_W-1:0] end_q, end_d;
    logic [NONCE_W-1:0] attempts_d, found_nonce_d;
    logic [NONCE_W:0]   sum;
    logic               can_start;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            nonce_q     <= '0;
            end_q       <= '0;
            attempts    <= '0;
            found_nonce <= '0;
        end else begin
            state       <= state_d;
            nonce_q     <= nonce_d;
            end_q       <= end_d;
            attempts    <= attempts_d;
            found_nonce <= found_nonce_d;
        end
    end

    always_comb begin
        state_d       = state;
        nonce_d       = nonce_q;
        end_d         = end_q;
        attempts_d    = attempts;
        found_nonce_d = found_nonce;
        // Carry bit catches overflow so the sweep never wraps to zero.
        sum           = {1'b0, nonce_q} + STEP_EXT;
        can_start     = (state == IDLE) || (state == FOUND) || (state == EXHAUSTED);

        if (abort) begin
            state_d       = IDLE;
            attempts_d    = '0;
            found_nonce_d = '0;
        end else if (start && can_start) begin
            nonce_d       = start_nonce;
            end_d         = end_nonce;
            attempts_d    = '0;
            found_nonce_d = '0;
            state_d       = (start_nonce > end_nonce) ? EXHAUSTED : PRESENT;
        end else begin
            case (state)
                PRESENT: begin
                    if (nonce_ready) begin
                        if (attempts != '1) attempts_d = attempts + 1'b1;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (found) begin
                        found_nonce_d = nonce_q;
                        state_d       = FOUND;
                    end else if (next) begin
                        if (sum[NONCE_W] || (sum[NONCE_W-1:0] > end_q)) begin
                            state_d = EXHAUSTED;
                        end else begin
                            nonce_d = sum[NONCE_W-1:0];
                            state_d = PRESENT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nonce_valid = (state == PRESENT);
        busy        = (state == PRESENT) || (state == WAIT);
        done        = (state == FOUND) || (state == EXHAUSTED);
        exhausted   = (state == EXHAUSTED);
        nonce_addr  = nonce_valid ? NONCE_ADDR : '0;
        nonce_out   = nonce_q;
`ifdef NONCE_BYTESWAP_EN
        for (int i = 0; i < NONCE_W / 8; i++) begin
            nonce_out[8*i +: 8] = nonce_q[NONCE_W-8-8*i +: 8];
        end
`endif
    end

endmodule
